mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Parametrised arbiter that shares one memory port between NUM_PORTS requesters (port 0 = fetch, port 1 = LSU, further ports reserved).
- Sits between the IF/Mem stages and main memory.
- Replaces the single shared grant line with per-port valid/ready handshakes.
- Adds round-robin fairness, response routing back to the issuing port, and a response timeout with an error flag.

Parameters:
- NUM_PORTS, 2, number of requesters (>=2).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 64, cycles to wait for a response before an error; 0 disables the timeout.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid_ip  in  NUM_PORTS  per-port request valid
- req_ready_op  out  NUM_PORTS  per-port request accepted (one-hot or zero)
- req_we_ip  in  NUM_PORTS  per-port write enable
- req_addr_ip  in  NUM_PORTS*ADDR_W  flattened addresses; port i at [i*ADDR_W +: ADDR_W]
- req_wdata_ip  in  NUM_PORTS*DATA_W  flattened write data
- rsp_valid_op  out  NUM_PORTS  one-cycle response pulse to the issuing port
- rsp_err_op  out  1  qualifies rsp_valid_op; 1 = timed out
- rsp_rdata_op  out  DATA_W  read data (0 on error or on write ack)
- mem_req_op  out  1  memory request
- mem_we_op  out  1  memory write enable
- mem_addr_op  out  ADDR_W  memory address
- mem_wdata_op  out  DATA_W  memory write data
- mem_gnt_ip  in  1  memory accepted the request
- mem_rvalid_ip  in  1  memory response/ack valid
- mem_rdata_ip  in  DATA_W  memory read data

Behaviour:
- Clocking: one clock. Reset is synchronous and active-high, sampled on the rising edge of clock.
- Reset values: state=IDLE, rr_ptr=0, every output 0, timeout counter 0.
- Reset mid-transaction abandons the transaction. Any later mem_rvalid_ip arriving in IDLE is ignored.
- One outstanding transaction at a time.
- IDLE state:
  - Winner is the first valid port scanning rr_ptr, rr_ptr+1, ... modulo NUM_PORTS.
  - req_ready_op[winner]=1, combinationally, in IDLE only; all other ready bits 0.
  - On handshake, register port id, we, addr and wdata; rr_ptr <= (winner+1) mod NUM_PORTS; go to REQ.
  - With no valid request, stay in IDLE and leave rr_ptr unchanged.
- REQ state:
  - mem_req_op=1; mem_we_op/addr/wdata driven from the registers and held stable.
  - On mem_gnt_ip, go to RESP and clear the counter; otherwise hold. No timeout applies in REQ.
- RESP state:
  - mem_req_op=0; the counter increments each cycle.
  - On mem_rvalid_ip: next cycle rsp_valid_op[id]=1, rsp_err_op=0, rsp_rdata_op = registered mem_rdata_ip for a read or 0 for a write; go to IDLE.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 without mem_rvalid_ip: next cycle rsp_valid_op[id]=1, rsp_err_op=1, rsp_rdata_op=0; go to IDLE.
  - If mem_rvalid_ip arrives in the same cycle as the timeout, the response wins (no error).
- Response outputs: rsp_valid_op and rsp_err_op are single-cycle pulses. rsp_rdata_op holds its value until the next response.
- Minimum latency: handshake at cycle 0, mem_req_op at cycle 1. With gnt at cycle 1 and rvalid at cycle 2, rsp_valid_op is at cycle 3.
- Back-to-back: the transition to IDLE happens on the rsp_valid_op edge, so a new handshake can occur in the same cycle rsp_valid_op is high.
- Changes to req_* inputs outside a handshake have no effect.

Optional Feature:
- MEM_ARB_STATS_EN defined:
  - Adds output stat_grants_op, width NUM_PORTS*16: per-port 16-bit grant counters, incremented on each handshake and saturating at 0xFFFF.
  - Adds output stat_timeouts_op, width 16: count of error responses, saturating.
  - All counters clear on reset.
- Not defined: neither port nor the counters exist; all other behaviour is identical.

Test Plan:
(All scenarios use NUM_PORTS=2, TIMEOUT_CYCLES=8.)
- Single read: port1 read addr 0x80; memory gives gnt the next cycle and rvalid with rdata=0xDEADBEEF 2 cycles later -> mem_addr_op=0x80 while mem_req_op=1; rsp_valid_op=2'b10, rsp_rdata_op=0xDEADBEEF, rsp_err_op=0.
- Fairness: both ports hold valid for 4 transactions -> grant order 0,1,0,1; each port receives exactly 2 responses, routed correctly.
- Write ack: port0 write addr 0x84, data 0x12345678 -> mem_we_op=1, mem_wdata_op=0x12345678; response rsp_valid_op=2'b01 with rsp_rdata_op=0.
- Timeout: grant the request but never assert rvalid -> after 8 RESP cycles rsp_valid_op pulses with rsp_err_op=1, rsp_rdata_op=0; a late rvalid in IDLE produces no response.
- Grant stall plus reset: hold mem_gnt_ip=0 for 20 cycles -> mem_req_op stays 1 with stable address and no error; then assert reset for 1 cycle -> all outputs 0, state IDLE, rr_ptr=0, and the next request with both ports valid grants port0.
- With MEM_ARB_STATS_EN: after the fairness plus timeout scenarios, per-port grant counts = 2 and 2 (plus one extra on the timed-out port), stat_timeouts_op=1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between NUM_PORTS requesters, one transaction in flight.
// Define MEM_ARB_STATS_EN to add saturating per-port grant and timeout counters.

module mem_port_arbiter #(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        req_valid_ip,
    output logic [NUM_PORTS-1:0]        req_ready_op,
    input  logic [NUM_PORTS-1:0]        req_we_ip,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr_ip,
    input  logic [NUM_PORTS*DATA_W-1:0] req_wdata_ip,
    output logic [NUM_PORTS-1:0]        rsp_valid_op,
    output logic                        rsp_err_op,
    output logic [DATA_W-1:0]           rsp_rdata_op,
    output logic                        mem_req_op,
    output logic                        mem_we_op,
    output logic [ADDR_W-1:0]           mem_addr_op,
    output logic [DATA_W-1:0]           mem_wdata_op,
    input  logic                        mem_gnt_ip,
    input  logic                        mem_rvalid_ip,
    input  logic [DATA_W-1:0]           mem_rdata_ip
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [NUM_PORTS*16-1:0]     stat_grants_op,
    output logic [15:0]                 stat_timeouts_op
`endif
);

    localparam int PTR_W = $clog2(NUM_PORTS);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP
    } state_e;

    state_e                 state_q, state_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]       id_q, id_d;
    logic                   we_q, we_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_PORTS-1:0]   rsp_valid_q, rsp_valid_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]      rsp_rdata_q, rsp_rdata_d;

    logic [PTR_W-1:0]       winner;
    logic                   win_found;
    logic                   timeout_hit;

    // Scan from rr_ptr upwards with wrap; the first valid port wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        winner    = '0;
        win_found = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_PORTS);
            if (!win_found && req_valid_ip[idx]) begin
                winner    = idx;
                win_found = 1'b1;
            end
        end
    end

    assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

    always_comb begin
        // NOTE: every signal gets a default before the case, so no path can infer a latch.
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        id_d         = id_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = '0;
        rsp_err_d    = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        req_ready_op = '0;
        mem_req_op   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    req_ready_op[winner] = 1'b1;
                    id_d     = winner;
                    we_d     = req_we_ip[winner];
                    addr_d   = req_addr_ip[int'(winner)*ADDR_W +: ADDR_W];
                    wdata_d  = req_wdata_ip[int'(winner)*DATA_W +: DATA_W];
                    rr_ptr_d = (winner == PTR_LAST) ? '0 : winner + PTR_W'(1);
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req_op = 1'b1;
                if (mem_gnt_ip) begin
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A response arriving on the timeout cycle takes priority over the error.
                if (mem_rvalid_ip) begin
                    rsp_valid_d[id_q] = 1'b1;
                    rsp_rdata_d       = we_q ? '0 : mem_rdata_ip;
                    state_d           = ST_IDLE;
                end else if (timeout_hit) begin
                    rsp_valid_d[id_q] = 1'b1;
                    rsp_err_d         = 1'b1;
                    rsp_rdata_d       = '0;
                    state_d           = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign mem_we_op    = we_q;
    assign mem_addr_op  = addr_q;
    assign mem_wdata_op = wdata_q;
    assign rsp_valid_op = rsp_valid_q;
    assign rsp_err_op   = rsp_err_q;
    assign rsp_rdata_op = rsp_rdata_q;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] grants_q [NUM_PORTS];
    logic [15:0] grants_d [NUM_PORTS];
    logic [15:0] timeouts_q, timeouts_d;

    always_comb begin
        grants_d   = grants_q;
        timeouts_d = timeouts_q;
        if (state_q == ST_IDLE && win_found && grants_q[winner] != 16'hFFFF) begin
            grants_d[winner] = grants_q[winner] + 16'd1;
        end
        if (state_q == ST_RESP && !mem_rvalid_ip && timeout_hit && timeouts_q != 16'hFFFF) begin
            timeouts_d = timeouts_q + 16'd1;
        end
    end

    // NOTE: the counter array is reset explicitly; software reads it as a clean zero after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                grants_q[i] <= '0;
            end
            timeouts_q <= '0;
        end else begin
            grants_q   <= grants_d;
            timeouts_q <= timeouts_d;
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_stat
        assign stat_grants_op[i*16 +: 16] = grants_q[i];
    end
    assign stat_timeouts_op = timeouts_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester driver, memory model, response monitor.
`timescale 1ns/1ps

module tb_mem_port_arbiter;

    localparam int NP = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic [NP-1:0]     req_valid_ip, req_ready_op, req_we_ip;
    logic [NP*AW-1:0]  req_addr_ip;
    logic [NP*DW-1:0]  req_wdata_ip;
    logic [NP-1:0]     rsp_valid_op;
    logic              rsp_err_op;
    logic [DW-1:0]     rsp_rdata_op;
    logic              mem_req_op, mem_we_op;
    logic [AW-1:0]     mem_addr_op;
    logic [DW-1:0]     mem_wdata_op;
    logic              mem_gnt_ip, mem_rvalid_ip;
    logic [DW-1:0]     mem_rdata_ip;
`ifdef MEM_ARB_STATS_EN
    logic [NP*16-1:0]  stat_grants_op;
    logic [15:0]       stat_timeouts_op;
`endif

    always #5 clock = ~clock;

    mem_port_arbiter #(
        .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid_ip(req_valid_ip), .req_ready_op(req_ready_op), .req_we_ip(req_we_ip),
        .req_addr_ip(req_addr_ip), .req_wdata_ip(req_wdata_ip),
        .rsp_valid_op(rsp_valid_op), .rsp_err_op(rsp_err_op), .rsp_rdata_op(rsp_rdata_op),
        .mem_req_op(mem_req_op), .mem_we_op(mem_we_op), .mem_addr_op(mem_addr_op),
        .mem_wdata_op(mem_wdata_op), .mem_gnt_ip(mem_gnt_ip), .mem_rvalid_ip(mem_rvalid_ip),
        .mem_rdata_ip(mem_rdata_ip)
`ifdef MEM_ARB_STATS_EN
        , .stat_grants_op(stat_grants_op), .stat_timeouts_op(stat_timeouts_op)
`endif
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          drop;   // memory grants but never answers
        int          gw;     // cycles before gnt
        int          rw;     // cycles from gnt to rvalid
    } req_t;

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rdata;
        int          hs_cyc;
        int          lat;
    } exp_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a == 32'h80) ? 32'hDEADBEEF : {a[15:0], 16'hC0DE};
    endfunction

    req_t req_arr [NP][16];
    int   wr_idx [NP] = '{0, 0};
    int   rd_idx [NP] = '{0, 0};
    req_t pres [NP];
    req_t cur;
    exp_t exp_q [$];
    int   grant_log [$];
    int   rsp_cnt [NP] = '{0, 0};
    int   cyc = 0;
    bit   mem_auto;
    int   late_req = 0;
    int   late_done = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic enqueue(input int p, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit drop, input int gw, input int rw);
        req_arr[p][wr_idx[p]] = '{we: we, addr: addr, wdata: wdata, drop: drop, gw: gw, rw: rw};
        wr_idx[p]++;
    endtask

    task automatic wait_quiet(input int max_cyc, input string tag);
        int  n;
        bit  quiet;
        n = 0;
        quiet = 1'b0;
        while (!quiet && n < max_cyc) begin
            @(negedge clock);
            n++;
            quiet = (rd_idx[0] == wr_idx[0]) && (rd_idx[1] == wr_idx[1]) &&
                    (req_valid_ip == '0) && (exp_q.size() == 0) && !mem_req_op;
        end
        check({tag, "_done"}, quiet, 1);
    endtask

    // Requester driver: presents queued requests, drops valid after each handshake.
    initial begin
        logic [NP-1:0] hs;
        req_valid_ip = '0;
        req_we_ip    = '0;
        req_addr_ip  = '0;
        req_wdata_ip = '0;
        forever begin
            @(negedge clock);
            hs = reset ? '0 : (req_valid_ip & req_ready_op);
            @(posedge clock);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (hs[p]) req_valid_ip[p] = 1'b0;
                if (!req_valid_ip[p] && rd_idx[p] < wr_idx[p]) begin
                    pres[p] = req_arr[p][rd_idx[p]];
                    rd_idx[p]++;
                    req_valid_ip[p]            = 1'b1;
                    req_we_ip[p]               = pres[p].we;
                    req_addr_ip[p*AW +: AW]    = pres[p].addr;
                    req_wdata_ip[p*DW +: DW]   = pres[p].wdata;
                end
            end
        end
    end

    // Memory model: timing taken from the request currently in flight.
    initial begin
        mem_gnt_ip    = 1'b0;
        mem_rvalid_ip = 1'b0;
        mem_rdata_ip  = '0;
        forever begin
            @(negedge clock);
            if (late_done < late_req) begin
                mem_rvalid_ip = 1'b1;
                mem_rdata_ip  = 32'hBAD0BAD0;
                @(negedge clock);
                mem_rvalid_ip = 1'b0;
                late_done++;
            end else if (mem_auto && mem_req_op && !reset) begin
                repeat (cur.gw) @(negedge clock);
                mem_gnt_ip = 1'b1;
                @(negedge clock);
                mem_gnt_ip = 1'b0;
                if (!cur.drop) begin
                    repeat (cur.rw - 1) @(negedge clock);
                    mem_rvalid_ip = 1'b1;
                    mem_rdata_ip  = cur.we ? 32'hFFFFFFFF : mem_data(cur.addr);
                    @(negedge clock);
                    mem_rvalid_ip = 1'b0;
                end
            end
        end
    end

    // Monitor: records handshakes into the scoreboard and checks every response.
    initial begin
        exp_t          e;
        int            p;
        logic [NP-1:0] oh;
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_q.delete();
            end else begin
                if (|req_valid_ip) check("ready_onehot", $onehot0(req_ready_op), 1);
                if (mem_req_op) begin
                    check("mem_addr", mem_addr_op, cur.addr);
                    check("mem_we", mem_we_op, cur.we);
                    check("mem_wdata", mem_wdata_op, cur.wdata);
                end
                if (|rsp_valid_op) begin
                    for (int i = 0; i < NP; i++) if (rsp_valid_op[i]) rsp_cnt[i]++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_rsp", rsp_valid_op, 0);
                    end else begin
                        e  = exp_q.pop_front();
                        oh = '0;
                        oh[e.port] = 1'b1;
                        check("rsp_port", rsp_valid_op, oh);
                        check("rsp_err", rsp_err_op, e.err);
                        check("rsp_rdata", rsp_rdata_op, e.rdata);
                        check("rsp_latency", cyc - e.hs_cyc, e.lat);
                    end
                end
                if (|(req_valid_ip & req_ready_op)) begin
                    p = 0;
                    for (int i = 0; i < NP; i++) if (req_ready_op[i]) p = i;
                    grant_log.push_back(p);
                    cur = pres[p];
                    exp_q.push_back('{port: p, err: cur.drop,
                                      rdata: (cur.drop || cur.we) ? 32'h0 : mem_data(cur.addr),
                                      hs_cyc: cyc,
                                      lat: cur.drop ? 2 + cur.gw + TO : 2 + cur.gw + cur.rw});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int base;
        int r0, r1;
        int n;
        reset    = 1'b1;
        mem_auto = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_rsp_valid", rsp_valid_op, 0);
        check("rst_rsp_err", rsp_err_op, 0);
        check("rst_rsp_rdata", rsp_rdata_op, 0);
        check("rst_mem_req", mem_req_op, 0);
        check("rst_mem_addr", mem_addr_op, 0);
        check("rst_ready", req_ready_op, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Single read from port 1
        enqueue(1, 1'b0, 32'h80, 32'h0, 1'b0, 0, 2);
        wait_quiet(100, "single_read");
        repeat (3) @(negedge clock);
        check("rdata_hold", rsp_rdata_op, 32'hDEADBEEF);

        // Fairness with both ports continuously valid
        base = grant_log.size();
        r0 = rsp_cnt[0];
        r1 = rsp_cnt[1];
        for (int i = 0; i < 2; i++) begin
            enqueue(0, 1'b0, 32'h200 + i*4, 32'h0, 1'b0, 1, 1);
            enqueue(1, 1'b0, 32'h300 + i*4, 32'h0, 1'b0, 0, 3);
        end
        wait_quiet(200, "fairness");
        check("fair_grants", grant_log.size() - base, 4);
        for (int i = 0; i < 4 && base + i < grant_log.size(); i++) begin
            check($sformatf("fair_order%0d", i), grant_log[base+i], i % 2);
        end
        check("fair_rsp_p0", rsp_cnt[0] - r0, 2);
        check("fair_rsp_p1", rsp_cnt[1] - r1, 2);

        // Write ack at minimum latency
        enqueue(0, 1'b1, 32'h84, 32'h12345678, 1'b0, 0, 1);
        wait_quiet(100, "write");

        // Timeout, then a stray rvalid while idle
        enqueue(1, 1'b0, 32'h90, 32'h0, 1'b1, 0, 0);
        wait_quiet(100, "timeout");
        late_req = 1;
        repeat (4) begin
            @(negedge clock);
            check("late_rvalid_no_rsp", rsp_valid_op, 0);
        end
        check("late_rvalid_sent", late_done, 1);
`ifdef MEM_ARB_STATS_EN
        check("stat_grants_p0", stat_grants_op[15:0], 3);
        check("stat_grants_p1", stat_grants_op[31:16], 4);
        check("stat_timeouts", stat_timeouts_op, 1);
`endif

        // rvalid on the timeout cycle: the response must win
        enqueue(1, 1'b0, 32'hA0, 32'h0, 1'b0, 0, TO);
        wait_quiet(100, "tie");

        // Grant stall followed by reset
        mem_auto = 1'b0;
        enqueue(0, 1'b0, 32'h100, 32'h0, 1'b0, 0, 1);
        n = 0;
        while (!mem_req_op && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("stall_req_seen", mem_req_op, 1);
        repeat (20) begin
            @(negedge clock);
            check("stall_req_held", mem_req_op, 1);
            check("stall_addr", mem_addr_op, 32'h100);
            check("stall_no_rsp", {rsp_valid_op, rsp_err_op}, 0);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst2_mem_req", mem_req_op, 0);
        check("rst2_mem_addr", mem_addr_op, 0);
        check("rst2_mem_we_wdata", {mem_we_op, mem_wdata_op}, 0);
        check("rst2_rsp", {rsp_valid_op, rsp_err_op}, 0);
        check("rst2_rdata", rsp_rdata_op, 0);
        check("rst2_ready", req_ready_op, 0);
        mem_auto = 1'b1;
        base = grant_log.size();
        enqueue(1, 1'b0, 32'h110, 32'h0, 1'b0, 0, 1);
        enqueue(0, 1'b0, 32'h114, 32'h0, 1'b0, 0, 1);
        wait_quiet(100, "post_reset");
        check("post_reset_grants", grant_log.size() - base, 2);
        if (grant_log.size() >= base + 2) begin
            check("post_reset_first", grant_log[base], 0);
            check("post_reset_second", grant_log[base+1], 1);
        end
`ifdef MEM_ARB_STATS_EN
        check("stat_rst_grants_p0", stat_grants_op[15:0], 1);
        check("stat_rst_grants_p1", stat_grants_op[31:16], 1);
        check("stat_rst_timeouts", stat_timeouts_op, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
